// File: rtl/dvs_ravens_pkg.sv
// Shared types and widths for the DVS-to-RAVENS event path.
package dvs_ravens_pkg;

    localparam int unsigned DVS_X_ADDR_BITS   = 9;
    localparam int unsigned DVS_Y_ADDR_BITS   = 9;
    localparam int unsigned TIMESTAMP_US_BITS = 16;
    localparam int unsigned DS_SHIFT_DEFAULT  = 3;

    localparam int unsigned DS_X_BITS      = DVS_X_ADDR_BITS - DS_SHIFT_DEFAULT;
    localparam int unsigned DS_Y_BITS      = DVS_Y_ADDR_BITS - DS_SHIFT_DEFAULT;
    localparam int unsigned NEURON_ID_BITS = DS_X_BITS + DS_Y_BITS + 1;

    typedef struct packed {
        logic [DVS_X_ADDR_BITS-1:0]   x;
        logic [DVS_Y_ADDR_BITS-1:0]   y;
        logic [TIMESTAMP_US_BITS-1:0] timestamp;
        logic                         polarity;
    } dvs_event_t;

    typedef enum logic {
        CMD_SPIKE = 1'b0,
        CMD_RUN   = 1'b1
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SPIKE     = 2'd1,
        RUN       = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

    // Downsampled neuron id: {y >> shift, x >> shift, polarity}.
    function automatic logic [NEURON_ID_BITS-1:0] neuron_id(
        input logic [DVS_X_ADDR_BITS-1:0] x,
        input logic [DVS_Y_ADDR_BITS-1:0] y,
        input logic                       pol,
        input int unsigned                shift
    );
        return {DS_Y_BITS'(y >> shift), DS_X_BITS'(x >> shift), pol};
    endfunction

endpackage

// File: rtl/dvs_event_fifo.sv
// Synchronous event FIFO with registered full/empty/level and a flush.
module dvs_event_fifo
    import dvs_ravens_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  dvs_event_t               i_wdata,
    output dvs_event_t               o_head_c,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    dvs_event_t    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nxt;
    logic          r_full;
    logic          r_empty;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !r_full && !i_flush;
    assign w_do_pop  = i_pop && !r_empty && !i_flush;

    // Next occupancy from accepted push/pop.
    always_comb begin
        w_level_nxt = r_level + LW'(w_do_push) - LW'(w_do_pop);
    end

    // Pointers and status flags; flush behaves like a local reset.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_head_c = r_mem[r_rptr];
    assign o_full   = r_full;
    assign o_empty  = r_empty;
    assign o_level  = r_level;

endmodule

// File: rtl/dvs_event_scheduler.sv
// Bins DVS events into microsecond timesteps and issues SPIKE/RUN commands to RAVENS.
module dvs_event_scheduler
    import dvs_ravens_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMESTEP_US = 1000,
    parameter int unsigned DS_SHIFT    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [TIMESTAMP_US_BITS-1:0] cur_timestamp,
    input  logic [DVS_X_ADDR_BITS-1:0]   event_x,
    input  logic [DVS_Y_ADDR_BITS-1:0]   event_y,
    input  logic [TIMESTAMP_US_BITS-1:0] event_timestamp,
    input  logic                         event_polarity,
    input  logic                         new_event,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic                         cmd_type,
    output logic [NEURON_ID_BITS-1:0]    cmd_data,
    input  logic                         ravens_done,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [15:0]                  drop_count,
    output logic                         busy
);

    localparam int unsigned TW = TIMESTAMP_US_BITS;
    localparam logic [TW-1:0] STEP = TW'(TIMESTEP_US);

    sched_state_e              r_state;
    sched_state_e              w_state_nxt;
    logic                      r_enable_d;
    logic [TW-1:0]             r_window_start;
    logic                      r_cmd_valid;
    logic                      r_cmd_type;
    logic [NEURON_ID_BITS-1:0] r_cmd_data;
    logic                      r_busy;
    logic [15:0]               r_drop_count;

    logic                      w_cmd_valid_nxt;
    logic                      w_cmd_type_nxt;
    logic [NEURON_ID_BITS-1:0] w_cmd_data_nxt;
    logic                      w_pop;
    logic                      w_advance;
    logic                      w_enable_rise;
    logic                      w_push;
    logic                      w_full;
    logic                      w_empty;
    dvs_event_t                w_wr_event;
    dvs_event_t                w_head;
    logic [TW-1:0]             w_age;
    logic [TW-1:0]             w_hd;
    logic                      w_expired;
    logic                      w_head_in_window;
    logic                      w_can_start;

    assign w_enable_rise = enable && !r_enable_d;
    assign w_push        = new_event && enable && !w_full;
    assign w_wr_event    = '{x: event_x, y: event_y, timestamp: event_timestamp,
                             polarity: event_polarity};

    dvs_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (w_enable_rise),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_wdata  (w_wr_event),
        .o_head_c (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (fifo_level)
    );

    // Modular window arithmetic; a head behind the window is clamped into it.
    assign w_age            = cur_timestamp - r_window_start;
    assign w_expired        = (w_age >= STEP);
    assign w_hd             = w_head.timestamp - r_window_start;
    assign w_head_in_window = (w_hd < STEP) || w_hd[TW-1];
    // Window start is being reloaded on the enable edge, so hold decisions one cycle.
    assign w_can_start      = enable && !w_enable_rise;

    // Next-state and registered command outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_valid_nxt = r_cmd_valid;
        w_cmd_type_nxt  = r_cmd_type;
        w_cmd_data_nxt  = r_cmd_data;
        w_pop           = 1'b0;
        w_advance       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_can_start && !w_empty && w_head_in_window) begin
                    w_state_nxt     = SPIKE;
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_type_nxt  = CMD_SPIKE;
                    w_cmd_data_nxt  = neuron_id(w_head.x, w_head.y, w_head.polarity, DS_SHIFT);
                end else if (w_can_start && w_expired) begin
                    w_state_nxt     = RUN;
                    w_cmd_valid_nxt = 1'b1;
                    w_cmd_type_nxt  = CMD_RUN;
                    w_cmd_data_nxt  = '0;
                end
            end
            SPIKE: begin
                if (cmd_ready) begin
                    w_pop           = 1'b1;
                    w_state_nxt     = IDLE;
                    w_cmd_valid_nxt = 1'b0;
                end
            end
            RUN: begin
                if (cmd_ready) begin
                    w_advance       = 1'b1;
                    w_state_nxt     = WAIT_DONE;
                    w_cmd_valid_nxt = 1'b0;
                end
            end
            WAIT_DONE: begin
                if (ravens_done) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt     = IDLE;
                w_cmd_valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM state and command output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= 1'b0;
            r_cmd_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_type  <= w_cmd_type_nxt;
            r_cmd_data  <= w_cmd_data_nxt;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    // Window start: resync on enable edge, otherwise advance one step per RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable_d     <= 1'b0;
            r_window_start <= '0;
        end else begin
            r_enable_d <= enable;
            if (w_enable_rise) r_window_start <= cur_timestamp;
            else if (w_advance) r_window_start <= r_window_start + STEP;
        end
    end

    // Saturating count of events refused by a full FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (new_event && enable && w_full && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_type   = r_cmd_type;
    assign cmd_data   = r_cmd_data;
    assign busy       = r_busy;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_dvs_event_scheduler.sv
// Self-checking bench for dvs_event_scheduler with a window-level reference model.
module tb_dvs_event_scheduler;
    import dvs_ravens_pkg::*;

    localparam int unsigned T        = 1000;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned SHIFT    = 3;
    localparam int unsigned DONE_DLY = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] cur_timestamp;
    logic [8:0]  event_x;
    logic [8:0]  event_y;
    logic [15:0] event_timestamp;
    logic        event_polarity;
    logic        new_event;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_type;
    logic [12:0] cmd_data;
    logic        ravens_done;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;
    logic        busy;

    always #5 clk = ~clk;

    dvs_event_scheduler #(
        .FIFO_DEPTH  (DEPTH),
        .TIMESTEP_US (T),
        .DS_SHIFT    (SHIFT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .cur_timestamp   (cur_timestamp),
        .event_x         (event_x),
        .event_y         (event_y),
        .event_timestamp (event_timestamp),
        .event_polarity  (event_polarity),
        .new_event       (new_event),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_type        (cmd_type),
        .cmd_data        (cmd_data),
        .ravens_done     (ravens_done),
        .fifo_level      (fifo_level),
        .drop_count      (drop_count),
        .busy            (busy)
    );

    typedef struct {
        int unsigned x;
        int unsigned y;
        int unsigned pol;
        logic [15:0] ts;
    } ev_t;

    int          n_pass = 0;
    int          n_total = 0;
    int          cycle = 0;
    int          tinc = 0;
    bit          rnd_ready = 0;
    bit          rnd_tinc = 0;
    int          done_cnt = 0;

    ev_t         evq[$];
    int unsigned exp_type[$];
    int unsigned exp_data[$];
    logic [15:0] exp_ws[$];
    int unsigned got_type[$];
    int unsigned got_data[$];
    int unsigned got_cyc[$];
    logic [15:0] got_ts[$];

    // Reference neuron id: downsample coordinates, pack as y:6 | x:6 | pol:1.
    function automatic int unsigned ref_id(input ev_t e);
        return ((e.y >> SHIFT) % 64) * 128 + ((e.x >> SHIFT) % 64) * 2 + (e.pol % 2);
    endfunction

    // Event belongs to the window starting at ws, or lies behind it.
    function automatic bit in_win(input logic [15:0] ts, input logic [15:0] ws);
        logic [15:0] d;
        d = ts - ws;
        return (32'(d) < T) || (32'(d) >= 32768);
    endfunction

    // Expected command stream: per window, spike in-window heads in order, then RUN.
    task automatic build_expected(input logic [15:0] ws0, input int nruns);
        ev_t         q[$];
        logic [15:0] ws;
        q = evq;
        ws = ws0;
        exp_type.delete();
        exp_data.delete();
        exp_ws.delete();
        while (q.size() > 0 && in_win(q[0].ts, ws)) begin
            exp_type.push_back(0);
            exp_data.push_back(ref_id(q[0]));
            void'(q.pop_front());
        end
        for (int r = 0; r < nruns; r++) begin
            exp_type.push_back(1);
            exp_data.push_back(0);
            exp_ws.push_back(ws);
            ws = ws + 16'(T);
            while (q.size() > 0 && in_win(q[0].ts, ws)) begin
                exp_type.push_back(0);
                exp_data.push_back(ref_id(q[0]));
                void'(q.pop_front());
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic chk_range(input string tag, input int unsigned obs,
                             input int unsigned lo, input int unsigned hi);
        n_total++;
        assert (obs >= lo && obs <= hi) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    endtask

    // One clock: log an acceptance, advance time, emulate RAVENS completion.
    task automatic step();
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            got_type.push_back(32'(cmd_type));
            got_data.push_back(32'(cmd_data));
            got_ts.push_back(cur_timestamp);
            got_cyc.push_back(cycle);
            if (cmd_type === 1'b1) done_cnt = DONE_DLY;
        end
        @(posedge clk);
        #1;
        cycle++;
        cur_timestamp = cur_timestamp + 16'(tinc);
        ravens_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) ravens_done = 1'b1;
        end
        if (rnd_ready) cmd_ready = ($urandom_range(0, 3) != 0);
        if (rnd_tinc)  tinc = int'($urandom_range(0, 20));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        new_event = 1'b0;
        cmd_ready = 1'b0;
        ravens_done = 1'b0;
        rnd_ready = 0;
        rnd_tinc = 0;
        tinc = 0;
        done_cnt = 0;
        step();
        step();
        rst = 1'b0;
        got_type.delete();
        got_data.delete();
        got_ts.delete();
        got_cyc.delete();
        evq.delete();
    endtask

    task automatic enable_at(input logic [15:0] ts);
        cur_timestamp = ts;
        enable = 1'b1;
        step();
        step();
    endtask

    task automatic push_event(input ev_t e);
        event_x = 9'(e.x);
        event_y = 9'(e.y);
        event_polarity = 1'(e.pol);
        event_timestamp = e.ts;
        new_event = 1'b1;
        step();
        new_event = 1'b0;
    endtask

    function automatic ev_t rand_ev(input logic [15:0] ts);
        ev_t e;
        e.x = $urandom_range(0, 511);
        e.y = $urandom_range(0, 511);
        e.pol = $urandom_range(0, 1);
        e.ts = ts;
        return e;
    endfunction

    task automatic run_until(input int n, input int budget);
        for (int i = 0; i < budget && got_type.size() < n; i++) step();
    endtask

    // Compare the first n accepted commands with the model stream.
    task automatic check_stream(input string tag, input int n, input int unsigned slack);
        int          k;
        int          lim;
        logic [15:0] age;
        k = 0;
        chk_range($sformatf("%s_count", tag), got_type.size(), n, 100000);
        lim = (got_type.size() < n) ? got_type.size() : n;
        for (int i = 0; i < lim; i++) begin
            chk($sformatf("%s_type[%0d]", tag, i), got_type[i], exp_type[i]);
            chk($sformatf("%s_data[%0d]", tag, i), got_data[i], exp_data[i]);
            if (exp_type[i] == 1) begin
                age = got_ts[i] - exp_ws[k];
                chk_range($sformatf("%s_run_age[%0d]", tag, k), 32'(age), T, T + slack);
                k++;
            end
        end
    endtask

    initial begin
        ev_t         e;
        logic [15:0] ws0;

        cur_timestamp = '0;
        event_x = '0;
        event_y = '0;
        event_timestamp = '0;
        event_polarity = 1'b0;

        // Reset values.
        do_reset();
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_type", 32'(cmd_type), 0);
        chk("rst_data", 32'(cmd_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_busy", 32'(busy), 0);

        // Empty windows still produce RUNs at 1000, 2000, 3000.
        enable_at(16'd0);
        cmd_ready = 1'b1;
        tinc = 1;
        build_expected(16'd0, 3);
        run_until(3, 4000);
        check_stream("empty", 3, 4);
        chk("empty_drop", 32'(drop_count), 0);

        // Single event: latency, id, then RUN; then disabled input is ignored.
        do_reset();
        enable_at(16'd0);
        cmd_ready = 1'b1;
        tinc = 1;
        e.x = 100; e.y = 37; e.pol = 1; e.ts = 16'd200;
        evq.push_back(e);
        push_event(e);
        chk("lat_valid_early", 32'(cmd_valid), 0);
        step();
        chk("lat_valid", 32'(cmd_valid), 1);
        chk("lat_type", 32'(cmd_type), 0);
        chk("lat_data", 32'(cmd_data), 537);
        build_expected(16'd0, 1);
        run_until(2, 2000);
        check_stream("single", 2, 4);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step();
        push_event(e);
        step();
        chk("dis_level", 32'(fifo_level), 0);
        chk("dis_busy", 32'(busy), 0);
        chk("dis_drop", 32'(drop_count), 0);

        // Overflow while stalled, then drain in push order.
        do_reset();
        enable_at(16'd0);
        for (int i = 0; i < 20; i++) begin
            e = rand_ev(16'(100 + i));
            evq.push_back(e);
            push_event(e);
        end
        chk("ovf_level", 32'(fifo_level), 16);
        chk("ovf_drop", 32'(drop_count), 4);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(cmd_valid), 1);
            chk("stall_type", 32'(cmd_type), 0);
            chk("stall_data", 32'(cmd_data), ref_id(evq[0]));
            step();
        end
        while (evq.size() > DEPTH) void'(evq.pop_back());
        build_expected(16'd0, 0);
        cmd_ready = 1'b1;
        run_until(16, 200);
        check_stream("drain", 16, 0);
        chk("drain_level", 32'(fifo_level), 0);

        // Events straddling a window boundary are split by a RUN.
        do_reset();
        enable_at(16'd0);
        cmd_ready = 1'b1;
        e = rand_ev(16'd900);
        evq.push_back(e);
        push_event(e);
        e = rand_ev(16'd1100);
        evq.push_back(e);
        push_event(e);
        build_expected(16'd0, 2);
        tinc = 10;
        run_until(3, 1000);
        check_stream("split", 3, 50);
        if (got_cyc.size() >= 3)
            chk_range("split_after_done", got_cyc[2] - got_cyc[1], DONE_DLY + 1, 1000);

        // Window straddling timestamp wrap.
        do_reset();
        ws0 = 16'd65036;
        enable_at(ws0);
        cmd_ready = 1'b1;
        e = rand_ev(16'd200);
        evq.push_back(e);
        push_event(e);
        build_expected(ws0, 1);
        tinc = 5;
        run_until(2, 400);
        check_stream("wrap", 2, 20);
        for (int i = 0; i < 50; i++) step();
        chk("wrap_no_burst", got_type.size(), 2);

        // Reset during a stalled SPIKE.
        do_reset();
        enable_at(16'd0);
        for (int i = 0; i < 18; i++) push_event(rand_ev(16'(10 + i)));
        chk("mid_drop", 32'(drop_count), 2);
        chk("mid_valid", 32'(cmd_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(cmd_valid), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_drop", 32'(drop_count), 0);

        // Randomized events, readiness and time advance against the window model.
        for (int it = 0; it < 2; it++) begin
            do_reset();
            ws0 = 16'($urandom);
            enable_at(ws0);
            rnd_ready = 1;
            for (int i = 0; i < 12; i++) begin
                e = rand_ev(ws0 + 16'($urandom_range(0, 3999)));
                evq.push_back(e);
                push_event(e);
            end
            build_expected(ws0, 5);
            rnd_tinc = 1;
            run_until(exp_type.size(), 5000);
            check_stream($sformatf("rnd%0d", it), exp_type.size(), 600);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
